cbfp1_blk_buf: RTL

- Producer-side partner of the CBFP stage-1 control unit.
- Collects butterfly output beats into a ping-pong block buffer and issues a one-cycle alert_cbfp pulse when a block is complete.
- Replays that block downstream when the control unit returns valid_mod2, so the samples line up with the computed block exponent.
- Sits between the stage-1 butterfly output and the CBFP scaling datapath.

---
 rtl/cbfp1_blk_buf.sv | 100 ++++++++++
 1 files changed

// File: rtl/cbfp1_blk_buf.sv
// cbfp1_blk_buf: ping-pong block buffer that alerts the CBFP control unit and replays each block on its valid_mod2 acknowledge.
module cbfp1_blk_buf #(
   parameter int LANES     = 16,
   parameter int W         = 16,
   parameter int BLK_BEATS = 4
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               din_valid,
   input  logic [LANES*W-1:0] din_re,
   input  logic [LANES*W-1:0] din_im,
   output logic               alert_cbfp,
   input  logic               valid_mod2,
   output logic               dout_valid,
   output logic [LANES*W-1:0] dout_re,
   output logic [LANES*W-1:0] dout_im,
   output logic               dout_last,
   output logic               ovf_err,
   output logic               ack_err
);
   localparam int DW = LANES*W;
   localparam int CW = $clog2(BLK_BEATS);
   localparam logic [CW-1:0] LAST = CW'(BLK_BEATS-1);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] READ = 1'b1;
   logic [DW-1:0] mem_re [2*BLK_BEATS];
   logic [DW-1:0] mem_im [2*BLK_BEATS];
   logic [0:0] st, nxt_st;
   logic wr_bank, rd_bank, nxt_bank;
   logic [CW-1:0] wr_cnt, rd_cnt, nxt_cnt;
   logic [1:0] full, full_n, pend, pend_n, nfull;
   logic wr_en, wr_last, rd_last, acc;
   assign wr_en   = din_valid && !full[wr_bank];
   assign wr_last = wr_en && (wr_cnt == LAST);
   assign rd_last = (st == READ) && (rd_cnt == LAST);
   assign nfull   = 2'(full[0]) + 2'(full[1]);
   // an acknowledge is only meaningful if a buffered block is still unclaimed
   assign acc     = valid_mod2 && (pend < nfull);
   assign pend_n  = pend + 2'(acc) - 2'(rd_last);
   assign dout_valid = (st == READ);
   assign dout_last  = rd_last;
   always_comb begin
      full_n = full;
      if (wr_last) full_n[wr_bank] = 1'b1;
      if (rd_last) full_n[rd_bank] = 1'b0;
   end
   // nxt_* names the beat shown next cycle; the output registers prefetch it
   always_comb begin
      nxt_st   = st;
      nxt_bank = rd_bank;
      nxt_cnt  = rd_cnt;
      if (st == IDLE) begin
         if (pend != 2'd0 || acc) begin
            nxt_st  = READ;
            nxt_cnt = '0;
         end
      end else if (rd_last) begin
         nxt_bank = ~rd_bank;
         nxt_cnt  = '0;
         nxt_st   = (pend_n != 2'd0) ? READ : IDLE;
      end else begin
         nxt_cnt = rd_cnt + CW'(1);
      end
   end
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_re[{wr_bank, wr_cnt}] <= din_re;
         mem_im[{wr_bank, wr_cnt}] <= din_im;
      end
   end
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_bank    <= 1'b0;
         rd_bank    <= 1'b0;
         wr_cnt     <= '0;
         rd_cnt     <= '0;
         full       <= '0;
         pend       <= '0;
         st         <= IDLE;
         alert_cbfp <= 1'b0;
         ovf_err    <= 1'b0;
         ack_err    <= 1'b0;
         dout_re    <= '0;
         dout_im    <= '0;
      end else begin
         if (wr_en) wr_cnt <= wr_last ? '0 : wr_cnt + CW'(1);
         if (wr_last) wr_bank <= ~wr_bank;
         full       <= full_n;
         alert_cbfp <= wr_last;
         ovf_err    <= ovf_err | (din_valid & full[wr_bank]);
         ack_err    <= ack_err | (valid_mod2 & ~acc);
         pend       <= pend_n;
         st         <= nxt_st;
         rd_bank    <= nxt_bank;
         rd_cnt     <= nxt_cnt;
         dout_re    <= (nxt_st == READ) ? mem_re[{nxt_bank, nxt_cnt}] : '0;
         dout_im    <= (nxt_st == READ) ? mem_im[{nxt_bank, nxt_cnt}] : '0;
      end
   end
endmodule
